// File: rtl/aes_decryption_pkg.sv
// aes_pkg: shared constants, types and GF(2^8) helpers for the AES-128
// decryption core.
//   NK, NR      : AES-128 key words and round count
//   aes_state_e : control states of the iterative core
//   rcon()      : round constants rcon[1..10]
//   gf_xtime(), gf_mul(), gf_inv() : arithmetic modulo x^8+x^4+x^3+x+1
//   sbox(), inv_sbox()             : S-box and its inverse, built from gf_inv
package aes_pkg;

  localparam int unsigned NK = 4;
  localparam logic [3:0]  NR = 4'd10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    KEYEXP  = 2'd1,
    DECRYPT = 2'd2
  } aes_state_e;

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] rc;
    case (idx)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  function automatic logic [7:0] gf_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) begin
        p = p ^ aa;
      end else begin
        p = p;
      end
      aa = gf_xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] a2, a3, a12, a15, a240;
    a2   = gf_mul(a, a);
    a3   = gf_mul(a2, a);
    a12  = gf_mul(gf_mul(a3, a3), gf_mul(a3, a3));
    a15  = gf_mul(a12, a3);
    a240 = gf_mul(a15, a15);
    a240 = gf_mul(a240, a240);
    a240 = gf_mul(a240, a240);
    a240 = gf_mul(a240, a240);
    return gf_mul(gf_mul(a240, a12), a2);
  endfunction

  // Forward affine transform: x ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] x;
    x = gf_inv(b);
    return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]}
             ^ {x[3:0], x[7:4]} ^ 8'h63;
  endfunction

  // Inverse affine transform: rotl1 ^ rotl3 ^ rotl6 ^ 0x05, then invert.
  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    logic [7:0] b;
    b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    return gf_inv(b);
  endfunction

endpackage

// File: rtl/aes_decryption_inv_round.sv
// aes_inv_round: one combinational inverse AES round.
//   st_i   : 128-bit state, byte 0 at bits [127:120], column-major
//   rk_i   : round key for this round
//   last_i : 1 skips InvMixColumns (final round)
//   st_o   : InvMixColumns(InvSubBytes(InvShiftRows(st_i)) ^ rk_i), or without
//            InvMixColumns when last_i=1
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] st_i,
  input  logic [127:0] rk_i,
  input  logic         last_i,
  output logic [127:0] st_o
);

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction

  logic [127:0] ark_s;

  // Row r rotates right by r: output column c takes input column (c-r) mod 4.
  always_comb begin
    ark_s = 128'h0;
    for (int c = 0; c < int'(NK); c++) begin
      for (int r = 0; r < 4; r++) begin
        ark_s[127 - 8*(4*c + r) -: 8] =
          inv_sbox(st_i[127 - 8*(4*((c - r) & 3) + r) -: 8]) ^ rk_i[127 - 8*(4*c + r) -: 8];
      end
    end
  end

  // Final round omits InvMixColumns.
  always_comb begin
    st_o = ark_s;
    if (!last_i) begin
      for (int c = 0; c < int'(NK); c++) begin
        st_o[127 - 32*c -: 32] = inv_mix_col(ark_s[127 - 32*c -: 32]);
      end
    end else begin
      st_o = ark_s;
    end
  end

endmodule

// File: rtl/aes_decryption.sv
// aes_decryption: iterative AES-128 decryption, one round per clock.
//   clk, rst_n : clock, synchronous active-low reset
//   start      : request, sampled only when idle
//   Message    : ciphertext (byte 0 at bit 127)
//   Key        : cipher key (same ordering)
//   busy       : high from the accepting edge until done
//   done       : one-cycle pulse, D_Message valid
//   D_Message  : plaintext, held until the next done
// Flow: 10 forward key steps to reach rk10, then 11 decrypt steps while the
// inverse key schedule walks rk back down to rk0.
module aes_decryption
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] Message,
  input  logic [127:0] Key,
  output logic         busy,
  output logic         done,
  output logic [127:0] D_Message
);

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [127:0] key_next(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3;
    n0 = k[127:96] ^ sub_word(rot_word(k[31:0])) ^ {rc, 24'h000000};
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0]  ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // Undoes key_next: the previous w3 is recovered first and feeds SubWord.
  function automatic logic [127:0] key_prev(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] p0, p1, p2, p3;
    p3 = k[31:0]  ^ k[63:32];
    p2 = k[63:32] ^ k[95:64];
    p1 = k[95:64] ^ k[127:96];
    p0 = k[127:96] ^ sub_word(rot_word(p3)) ^ {rc, 24'h000000};
    return {p0, p1, p2, p3};
  endfunction

  aes_state_e   state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] st_q, st_d;
  logic [127:0] rk_q, rk_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic [127:0] dout_q, dout_d;
  logic [127:0] round_s;
  logic         last_s;

  assign last_s = (cnt_q == NR);

  aes_inv_round u_round (
    .st_i   (st_q),
    .rk_i   (rk_q),
    .last_i (last_s),
    .st_o   (round_s)
  );

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      st_q    <= 128'h0;
      rk_q    <= 128'h0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dout_q  <= 128'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      st_q    <= st_d;
      rk_q    <= rk_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dout_q  <= dout_d;
    end
  end

  // Next-state logic. In DECRYPT, step s uses rk_(10-s) and then steps the
  // key back with rcon[10-s] so the following round finds its key ready.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    st_d    = st_q;
    rk_d    = rk_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dout_d  = dout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          st_d    = Message;
          rk_d    = Key;
          cnt_d   = 4'd0;
          busy_d  = 1'b1;
          state_d = KEYEXP;
        end else begin
          state_d = IDLE;
        end
      end
      KEYEXP: begin
        rk_d = key_next(rk_q, rcon(cnt_q + 4'd1));
        if (cnt_q == NR - 4'd1) begin
          cnt_d   = 4'd0;
          state_d = DECRYPT;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DECRYPT: begin
        if (cnt_q == 4'd0) begin
          st_d  = st_q ^ rk_q;
          rk_d  = key_prev(rk_q, rcon(NR - cnt_q));
          cnt_d = 4'd1;
        end else if (cnt_q == NR) begin
          dout_d  = round_s;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          cnt_d   = 4'd0;
          state_d = IDLE;
        end else begin
          st_d  = round_s;
          rk_d  = key_prev(rk_q, rcon(NR - cnt_q));
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        cnt_d   = 4'd0;
      end
    endcase
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign D_Message = dout_q;

endmodule

// File: tb/tb_aes_decryption.sv
module tb_aes_decryption;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [127:0] Message;
  logic [127:0] Key;
  logic         busy;
  logic         done;
  logic [127:0] D_Message;

  always #5 clk = ~clk;

  aes_decryption dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .Message   (Message),
    .Key       (Key),
    .busy      (busy),
    .done      (done),
    .D_Message (D_Message)
  );

  localparam logic [127:0] K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;

  typedef struct {
    logic [127:0] pt;
    int           at;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 required no done (cycle %0d)", cyc);
      end else begin
        mon_e = sb_q.pop_front();
        check("plaintext", D_Message, mon_e.pt);
        check("done_cycle", 128'(cyc), 128'(mon_e.at));
        check("busy_in_done", {127'h0, busy}, 128'h0);
      end
    end
  end

  // Launch one block; done is due 22 sampled negedges after the setup negedge.
  task automatic issue(input logic [127:0] ct, input logic [127:0] k,
                       input logic [127:0] pt, input bit push);
    @(negedge clk);
    Message = ct;
    Key     = k;
    start   = 1'b1;
    if (push) sb_q.push_back('{pt, cyc + 22});
    @(negedge clk);
    start = 1'b0;
    check("busy_after_accept", {127'h0, busy}, 128'h1);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout: got %0d pending required 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    int n;
    rst_n   = 1'b0;
    start   = 1'b0;
    Message = 128'h0;
    Key     = 128'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset state, stable with start low.
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("reset_state", {busy, done, D_Message}, 130'h0);
    end

    // FIPS-197 C.1 and App. B vectors.
    issue(CT_C1, K_C1, PT_C1, 1'b1);
    drain(40);
    issue(CT_B, K_B, PT_B, 1'b1);
    drain(40);

    // Starts while busy are ignored; inputs changed after acceptance.
    issue(CT_C1, K_C1, PT_C1, 1'b1);
    Message = CT_B;
    Key     = K_B;
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain(40);
    repeat (10) @(negedge clk);
    check("idle_after_ignored", {127'h0, busy}, 128'h0);

    // Back-to-back with start held through the done cycle.
    @(negedge clk);
    Message = CT_C1;
    Key     = K_C1;
    start   = 1'b1;
    sb_q.push_back('{PT_C1, cyc + 22});
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    Message = CT_B;
    Key     = K_B;
    sb_q.push_back('{PT_B, cyc + 22});
    @(negedge clk);
    start = 1'b0;
    check("busy_b2b", {127'h0, busy}, 128'h1);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      check("hold_first", D_Message, PT_C1);
      @(negedge clk);
      n++;
    end
    drain(40);

    // Reset mid-block: no result and outputs cleared.
    issue(CT_B, K_B, PT_B, 1'b0);
    repeat (12) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_clear", {busy, done, D_Message}, 130'h0);
    repeat (40) @(negedge clk);
    check("abort_idle", {busy, D_Message}, 129'h0);

    // Fresh run after abort.
    issue(CT_C1, K_C1, PT_C1, 1'b1);
    drain(40);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
